id_ex_stage: RTL and testbench

- ID/EX pipeline register with integrated load-use hazard detection.
- Captures decoded instruction fields and register operands from ID and presents them to EX.
- The forwarding unit consumes ex_opcode, ex_rs, ex_rt and ex_rd (as ID_EX_rs/ID_EX_rt, and downstream as EX_MEM/MEM_WB opcode/rd).
- Inserts a one-cycle bubble and stalls PC and IF/ID when the instruction in EX is a load whose destination is read by the instruction in ID.

---
 rtl/id_ex_stage.sv | 129 ++++++++++++
 tb/tb_id_ex_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional STALL_CNT_EN macro builds saturating bubble/flush performance counters.
module id_ex_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter logic [5:0]  LW_OPCODE  = 6'b100011,
    parameter logic [5:0]  NOP_OPCODE = 6'b000000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_reads_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              flush,
    input  logic              ext_stall,
    output logic              ex_valid,
    output logic [5:0]        ex_opcode,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic              stall,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [5:0]        opcode;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
    } ex_t;

    ex_t  ex_q, ex_d;
    logic hazard;

    // Load in EX whose nonzero destination is read by the live instruction in ID.
    always_comb begin
        hazard = ex_q.valid && id_valid && (ex_q.opcode == LW_OPCODE) &&
                 (ex_q.rd != 5'd0) &&
                 ((ex_q.rd == id_rs) || (id_reads_rt && (ex_q.rd == id_rt)));
    end

    assign stall = hazard && !flush && !ext_stall;

    always_comb begin
        ex_d = ex_q;
        if (ext_stall) begin
            ex_d = ex_q;
        end else if (flush || hazard) begin
            ex_d        = '0;
            ex_d.opcode = NOP_OPCODE;
        end else begin
            // Dead slots carry NOP/zero register ids so forwarding never matches them.
            ex_d.valid   = id_valid;
            ex_d.opcode  = id_valid ? id_opcode : NOP_OPCODE;
            ex_d.rs      = id_valid ? id_rs : 5'd0;
            ex_d.rt      = id_valid ? id_rt : 5'd0;
            ex_d.rd      = id_valid ? id_rd : 5'd0;
            ex_d.rs_data = id_rs_data;
            ex_d.rt_data = id_rt_data;
            ex_d.imm     = id_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid   = ex_q.valid;
    assign ex_opcode  = ex_q.opcode;
    assign ex_rs      = ex_q.rs;
    assign ex_rt      = ex_q.rt;
    assign ex_rd      = ex_q.rd;
    assign ex_rs_data = ex_q.rs_data;
    assign ex_rt_data = ex_q.rt_data;
    assign ex_imm     = ex_q.imm;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters; frozen while the pipeline is held.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (!ext_stall) begin
            if (flush) begin
                if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end else if (hazard) begin
                if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`else
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a reference model pushes the expected EX
// contents to a queue each cycle, popped and compared after the clock edge.
module tb_id_ex_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam logic [5:0]  LW     = 6'b100011;
    localparam logic [5:0]  ADD    = 6'b000000;
    localparam logic [5:0]  ADDI   = 6'b001000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [5:0]        id_opcode;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic              id_reads_rt;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
    logic              flush, ext_stall;
    logic              ex_valid;
    logic [5:0]        ex_opcode;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
    logic              stall;
    logic [CNT_W-1:0]  bubble_cnt, flush_cnt;

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_reads_rt(id_reads_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .flush(flush), .ext_stall(ext_stall),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .stall(stall), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              valid;
        logic [5:0]        op;
        logic [4:0]        rs, rt, rd;
        logic [DATA_W-1:0] rsd, rtd, imm;
        logic [CNT_W-1:0]  bc, fc;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ex(input string tag, input exp_t e);
        chk({tag, ".valid"}, 32'(ex_valid), 32'(e.valid));
        chk({tag, ".op"}, 32'(ex_opcode), 32'(e.op));
        chk({tag, ".rs"}, 32'(ex_rs), 32'(e.rs));
        chk({tag, ".rt"}, 32'(ex_rt), 32'(e.rt));
        chk({tag, ".rd"}, 32'(ex_rd), 32'(e.rd));
        chk({tag, ".rsd"}, ex_rs_data, e.rsd);
        chk({tag, ".rtd"}, ex_rt_data, e.rtd);
        chk({tag, ".imm"}, ex_imm, e.imm);
`ifdef STALL_CNT_EN
        chk({tag, ".bcnt"}, 32'(bubble_cnt), 32'(e.bc));
        chk({tag, ".fcnt"}, 32'(flush_cnt), 32'(e.fc));
`else
        chk({tag, ".bcnt"}, 32'(bubble_cnt), 32'd0);
        chk({tag, ".fcnt"}, 32'(flush_cnt), 32'd0);
`endif
    endtask

    task automatic set_id(input logic v, input logic [5:0] op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic rrt);
        id_valid    = v;
        id_opcode   = op;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        id_reads_rt = rrt;
        id_rs_data  = $urandom;
        id_rt_data  = $urandom;
        id_imm      = $urandom;
    endtask

    // One clock: check directed stall, advance the model, compare EX after the edge.
    task automatic step(input string tag, input logic exp_stall);
        logic hz;
        exp_t e;
        #1;
        chk({tag, ".stall"}, 32'(stall), 32'(exp_stall));
        hz = m.valid && id_valid && (m.op == LW) && (m.rd != 5'd0) &&
             ((m.rd == id_rs) || (id_reads_rt && (m.rd == id_rt)));
        if (!ext_stall) begin
            if (flush || hz) begin
                m.valid = 1'b0; m.op = ADD; m.rs = '0; m.rt = '0; m.rd = '0;
                m.rsd = '0; m.rtd = '0; m.imm = '0;
                if (flush) begin
                    if (m.fc != 4'hF) m.fc = m.fc + 4'd1;
                end else if (m.bc != 4'hF) begin
                    m.bc = m.bc + 4'd1;
                end
            end else begin
                m.valid = id_valid;
                m.op  = id_valid ? id_opcode : 6'd0;
                m.rs  = id_valid ? id_rs : 5'd0;
                m.rt  = id_valid ? id_rt : 5'd0;
                m.rd  = id_valid ? id_rd : 5'd0;
                m.rsd = id_rs_data; m.rtd = id_rt_data; m.imm = id_imm;
            end
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk_ex(tag, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m = '0;
        flush = 1'b0; ext_stall = 1'b0;
        set_id(1'b0, ADD, 5'd0, 5'd0, 5'd0, 1'b0);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk_ex("reset", m);
        chk("reset.stall", 32'(stall), 32'd0);
        rst_n = 1'b1;

        // Load-use on rs: exactly one bubble, then the consumer loads.
        set_id(1'b1, LW, 5'd1, 5'd2, 5'd5, 1'b0);  step("lw5", 1'b0);
        set_id(1'b1, ADD, 5'd5, 5'd6, 5'd8, 1'b1); step("use_rs", 1'b1);
        chk("bubble.op", 32'(ex_opcode), 32'd0);
        chk("bubble.valid", 32'(ex_valid), 32'd0);
        step("use_rs_load", 1'b0);
        chk("use_rs.ex_rs", 32'(ex_rs), 32'd5);

        // Reset asserted mid-stall with nonzero inputs.
        set_id(1'b1, LW, 5'd3, 5'd4, 5'd9, 1'b0);  step("lw9", 1'b0);
        set_id(1'b1, ADD, 5'd9, 5'd9, 5'd1, 1'b1); flush = 1'b0;
        #1 chk("pre_rst.stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1 m = '0;
        chk_ex("mid_rst", m);
        chk("mid_rst.stall", 32'(stall), 32'd0);
        #1 rst_n = 1'b1;
        set_id(1'b0, LW, 5'd9, 5'd9, 5'd9, 1'b1);  step("post_rst_idle", 1'b0);

        // rt gating and register $0.
        set_id(1'b1, LW, 5'd1, 5'd2, 5'd7, 1'b0);  step("lw7", 1'b0);
        set_id(1'b1, ADDI, 5'd3, 5'd7, 5'd4, 1'b0); step("rt_noread", 1'b0);
        set_id(1'b1, LW, 5'd1, 5'd2, 5'd7, 1'b0);  step("lw7b", 1'b0);
        set_id(1'b1, ADD, 5'd3, 5'd7, 5'd4, 1'b1); step("rt_read", 1'b1);
        step("rt_read_load", 1'b0);
        set_id(1'b1, LW, 5'd1, 5'd2, 5'd0, 1'b0);  step("lw0", 1'b0);
        set_id(1'b1, ADD, 5'd0, 5'd0, 5'd4, 1'b1); step("r0_use", 1'b0);

        // Flush beats a simultaneous hazard.
        set_id(1'b1, LW, 5'd1, 5'd2, 5'd4, 1'b0);  step("lw4", 1'b0);
        set_id(1'b1, ADD, 5'd4, 5'd2, 5'd6, 1'b1); flush = 1'b1;
        step("flush_hz", 1'b0);
        flush = 1'b0;
        set_id(1'b1, ADD, 5'd4, 5'd2, 5'd6, 1'b1); step("after_flush", 1'b0);

        // ext_stall holds EX even across a flush pulse and a pending hazard.
        set_id(1'b1, ADDI, 5'd2, 5'd0, 5'd3, 1'b0); step("addi3", 1'b0);
        ext_stall = 1'b1;
        set_id(1'b1, ADD, 5'd3, 5'd3, 5'd1, 1'b1); step("hold1", 1'b0);
        flush = 1'b1;
        set_id(1'b1, LW, 5'd8, 5'd9, 5'd2, 1'b0);  step("hold2", 1'b0);
        flush = 1'b0;
        set_id(1'b0, ADD, 5'd1, 5'd1, 5'd1, 1'b1); step("hold3", 1'b0);
        chk("hold.ex_rd", 32'(ex_rd), 32'd3);
        ext_stall = 1'b0;
        set_id(1'b1, LW, 5'd1, 5'd2, 5'd2, 1'b0);  step("lw2", 1'b0);
        ext_stall = 1'b1;
        set_id(1'b1, ADD, 5'd2, 5'd0, 5'd1, 1'b0); step("hold_hz", 1'b0);
        ext_stall = 1'b0;
        step("release_hz", 1'b1);
        step("release_load", 1'b0);

        // Back-to-back loads to the same rd stall only their own consumer.
        set_id(1'b1, LW, 5'd1, 5'd2, 5'd5, 1'b0);  step("b2b_lw1", 1'b0);
        set_id(1'b1, LW, 5'd10, 5'd2, 5'd5, 1'b0); step("b2b_lw2", 1'b0);
        set_id(1'b1, ADD, 5'd5, 5'd2, 5'd6, 1'b1); step("b2b_use", 1'b1);
        step("b2b_use_load", 1'b0);

        // Twenty more load-use bubbles drive the 4-bit counter into saturation.
        for (int i = 0; i < 20; i++) begin
            set_id(1'b1, LW, 5'd1, 5'd2, 5'd6, 1'b0);  step("sat_lw", 1'b0);
            set_id(1'b1, ADD, 5'd6, 5'd2, 5'd7, 1'b1); step("sat_use", 1'b1);
            step("sat_load", 1'b0);
        end
`ifdef STALL_CNT_EN
        chk("bcnt_sat", 32'(bubble_cnt), 32'd15);
        chk("fcnt_final", 32'(flush_cnt), 32'd1);
`else
        chk("bcnt_tied", 32'(bubble_cnt), 32'd0);
        chk("fcnt_tied", 32'(flush_cnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
